// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared encodings for the data-memory arbiter
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way winner selection, prio breaks ties
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic prio,
    output logic grant_valid,
    output logic grant_owner
);

    assign grant_valid = a_req | b_req;
    assign grant_owner = (a_req & b_req) ? prio : (b_req ? OWN_B : OWN_A);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises pipeline and debug accesses onto one memory bus
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    output logic          a_stall,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          b_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t           state;
    logic             prio;
    logic             owner;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic             grant_valid;
    logic             grant_owner;
    logic             g_we;
    logic [AW-1:0]    g_addr;
    logic [DW-1:0]    g_wdata;

    rr_pick2 u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .prio        (prio),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign g_we    = grant_owner ? b_we    : a_we;
    assign g_addr  = grant_owner ? b_addr  : a_addr;
    assign g_wdata = grant_owner ? b_wdata : a_wdata;
    assign a_stall = a_req & ~a_ack;
    assign b_stall = b_req & ~b_ack;
    assign busy    = state != IDLE;

    // Sequencer: grant, drive bus, wait out read latency, acknowledge owner
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            prio      <= OWN_A;
            owner     <= OWN_A;
            we_q      <= 1'b0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (grant_valid) begin
                    owner     <= grant_owner;
                    we_q      <= g_we;
                    mem_we    <= g_we;
                    mem_addr  <= g_addr;
                    mem_wdata <= g_wdata;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    cnt   <= CNT_W'(RD_LAT);
                    state <= we_q ? DONE : WAIT_RD;
                    a_ack <= we_q && owner == OWN_A;
                    b_ack <= we_q && owner == OWN_B;
                end
                WAIT_RD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        if (owner == OWN_B) b_rdata <= mem_rdata;
                        else a_rdata <= mem_rdata;
                        a_ack <= owner == OWN_A;
                        b_ack <= owner == OWN_B;
                        state <= DONE;
                    end
                end
                default: begin
                    prio  <= (owner == OWN_A) ? OWN_B : OWN_A;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of two arbiters (RD_LAT 1 and 3)
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [1:0]  a_req, a_we, b_req, b_we;
    logic [31:0] a_addr [2], a_wdata [2], b_addr [2], b_wdata [2], mem_rdata [2];
    wire  [1:0]  a_ack, a_stall, b_ack, b_stall, mem_we, busy;
    wire  [31:0] a_rdata [2], b_rdata [2], mem_addr [2], mem_wdata [2];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clock     (clock),
            .resetn    (resetn),
            .a_req     (a_req[g]),
            .a_we      (a_we[g]),
            .a_addr    (a_addr[g]),
            .a_wdata   (a_wdata[g]),
            .a_ack     (a_ack[g]),
            .a_rdata   (a_rdata[g]),
            .a_stall   (a_stall[g]),
            .b_req     (b_req[g]),
            .b_we      (b_we[g]),
            .b_addr    (b_addr[g]),
            .b_wdata   (b_wdata[g]),
            .b_ack     (b_ack[g]),
            .b_rdata   (b_rdata[g]),
            .b_stall   (b_stall[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
    end

    // transaction-level reference: one outstanding access per arbiter, timed by its start cycle
    bit          act [2], own [2], twe [2], prio [2];
    int          t0 [2], tack [2];
    logic [31:0] taddr [2], twd [2], e_addr [2], e_wd [2], e_ard [2], e_brd [2];
    bit          x_busy [2], x_we [2], x_aack [2], x_back [2];
    bit          pa [2], pb [2], oa [2], ob [2], sa [2], sb [2];
    bit          rnd;
    int          cyc, n_chk, n_fail;

    function automatic int lat(int k);
        return k == 0 ? 1 : 3;
    endfunction

    function automatic logic [31:0] mdat(logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h12345678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; prio[k] = 0;
            e_addr[k] = '0; e_wd[k] = '0; e_ard[k] = '0; e_brd[k] = '0;
            pa[k] = 0; pb[k] = 0; oa[k] = 0; ob[k] = 0; sa[k] = 0; sb[k] = 0;
            a_req[k] = 0; b_req[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int c = cyc;
        if (act[k] && c > tack[k]) act[k] = 0;
        if (!act[k] && (a_req[k] || b_req[k])) begin
            own[k]   = (a_req[k] && b_req[k]) ? prio[k] : b_req[k];
            twe[k]   = own[k] ? b_we[k] : a_we[k];
            taddr[k] = own[k] ? b_addr[k] : a_addr[k];
            twd[k]   = own[k] ? b_wdata[k] : a_wdata[k];
            t0[k]    = c;
            tack[k]  = c + 2 + (twe[k] ? 0 : lat(k));
            act[k]   = 1;
        end
        if (act[k] && c == t0[k] + 1) begin
            e_addr[k] = taddr[k];
            e_wd[k]   = twd[k];
        end
        mem_rdata[k] = (act[k] && !twe[k] && c == t0[k] + 1 + lat(k)) ? mdat(taddr[k]) : $urandom;
        x_busy[k] = act[k] && c > t0[k];
        x_we[k]   = act[k] && twe[k] && c == t0[k] + 1;
        x_aack[k] = act[k] && c == tack[k] && !own[k];
        x_back[k] = act[k] && c == tack[k] && own[k];
        if (act[k] && c == tack[k]) begin
            if (!twe[k]) begin
                if (own[k]) e_brd[k] = mdat(taddr[k]);
                else e_ard[k] = mdat(taddr[k]);
            end
            prio[k] = !own[k];
        end
    endtask

    task automatic check_outputs(input int k);
        string p = (k == 0) ? "lat1." : "lat3.";
        chk({p, "busy"}, busy[k], x_busy[k]);
        chk({p, "mem_we"}, mem_we[k], x_we[k]);
        chk({p, "mem_addr"}, mem_addr[k], e_addr[k]);
        chk({p, "mem_wdata"}, mem_wdata[k], e_wd[k]);
        chk({p, "a_ack"}, a_ack[k], x_aack[k]);
        chk({p, "b_ack"}, b_ack[k], x_back[k]);
        chk({p, "a_rdata"}, a_rdata[k], e_ard[k]);
        chk({p, "b_rdata"}, b_rdata[k], e_brd[k]);
        chk({p, "a_stall"}, a_stall[k], a_req[k] & !x_aack[k]);
        chk({p, "b_stall"}, b_stall[k], b_req[k] & !x_back[k]);
        sa[k] = a_ack[k];
        sb[k] = b_ack[k];
    endtask

    task automatic rand_stim(input int k);
        if (sa[k]) begin pa[k] = 0; oa[k] = 0; end
        if (sb[k]) begin pb[k] = 0; ob[k] = 0; end
        if (pa[k] && act[k] && !own[k] && cyc > t0[k] && cyc < tack[k] && $urandom_range(15) == 0) begin
            a_req[k] = 0; pa[k] = 0; oa[k] = 1;
        end else if (!pa[k]) begin
            if (!oa[k] && $urandom_range(1) == 1) begin
                a_req[k] = 1; a_we[k] = $urandom_range(1) == 1;
                a_addr[k] = $urandom_range(255); a_wdata[k] = $urandom; pa[k] = 1;
            end else a_req[k] = 0;
        end
        if (pb[k] && act[k] && own[k] && cyc > t0[k] && cyc < tack[k] && $urandom_range(15) == 0) begin
            b_req[k] = 0; pb[k] = 0; ob[k] = 1;
        end else if (!pb[k]) begin
            if (!ob[k] && $urandom_range(1) == 1) begin
                b_req[k] = 1; b_we[k] = $urandom_range(1) == 1;
                b_addr[k] = $urandom_range(255); b_wdata[k] = $urandom; pb[k] = 1;
            end else b_req[k] = 0;
        end
    endtask

    task automatic cyc_begin();
        @(posedge clock);
        #1;
        cyc++;
        if (rnd) for (int k = 0; k < 2; k++) rand_stim(k);
    endtask

    task automatic cyc_end();
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clock);
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    task automatic tick();
        cyc_begin();
        cyc_end();
    endtask

    initial begin
        bit we_seen;
        int order [$];
        resetn = 0; rnd = 0; cyc = 0; n_chk = 0; n_fail = 0;
        a_we = '0; b_we = '0;
        for (int k = 0; k < 2; k++) begin
            a_addr[k] = '0; a_wdata[k] = '0; b_addr[k] = '0; b_wdata[k] = '0; mem_rdata[k] = '0;
        end
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock) resetn = 1;

        tick();
        chk("reset mem_addr", mem_addr[0], 32'h0);
        chk("reset busy", busy[0], 1'b0);

        cyc_begin();
        a_req[0] = 1; a_we[0] = 1; a_addr[0] = 32'h10; a_wdata[0] = 32'hDEADBEEF;
        cyc_end();
        chk("wr c0 stall", a_stall[0], 1'b1);
        tick();
        chk("wr c1 mem_we", mem_we[0], 1'b1);
        chk("wr c1 mem_addr", mem_addr[0], 32'h10);
        chk("wr c1 mem_wdata", mem_wdata[0], 32'hDEADBEEF);
        chk("wr c1 stall", a_stall[0], 1'b1);
        tick();
        chk("wr c2 ack", a_ack[0], 1'b1);
        chk("wr c2 stall", a_stall[0], 1'b0);
        cyc_begin();
        a_req[0] = 0;
        cyc_end();
        chk("wr c3 ack", a_ack[0], 1'b0);

        cyc_begin();
        b_req[0] = 1; b_we[0] = 0; b_addr[0] = 32'h0;
        cyc_end();
        we_seen = mem_we[0];
        for (int i = 1; i <= 3; i++) begin
            tick();
            we_seen |= mem_we[0];
            chk("rd b_ack", b_ack[0], i == 3);
        end
        chk("rd b_rdata", b_rdata[0], 32'h12345678);
        chk("rd a_rdata kept", a_rdata[0], 32'h0);
        chk("rd no mem_we", we_seen, 1'b0);
        cyc_begin();
        b_req[0] = 0;
        cyc_end();

        cyc_begin();
        a_req[0] = 1; a_we[0] = 1; a_addr[0] = 32'h20; a_wdata[0] = 32'h55;
        cyc_end();
        tick();
        chk("rstw access mem_we", mem_we[0], 1'b1);
        #1 resetn = 0;
        #1;
        chk("rstw async mem_we", mem_we[0], 1'b0);
        chk("rstw busy", busy[0], 1'b0);
        chk("rstw b_rdata", b_rdata[0], 32'h0);
        model_reset();
        @(negedge clock) resetn = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstw no ack", a_ack[0], 1'b0);
        end

        cyc_begin();
        a_req[0] = 1; a_we[0] = 1; a_addr[0] = 32'h30; a_wdata[0] = 32'h1;
        b_req[0] = 1; b_we[0] = 0; b_addr[0] = 32'h40;
        cyc_end();
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            if (a_ack[0]) order.push_back(0);
            if (b_ack[0]) order.push_back(1);
            if (order.size() < 4) tick();
        end
        chk("rr grant count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("rr grant order", order[i], i % 2);
        cyc_begin();
        a_req[0] = 0; b_req[0] = 0;
        cyc_end();
        repeat (8) tick();

        cyc_begin();
        a_req[1] = 1; a_we[1] = 0; a_addr[1] = 32'h80;
        cyc_end();
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("lat3 addr hold", mem_addr[1], 32'h80);
            chk("lat3 a_ack", a_ack[1], i == 5);
        end
        chk("lat3 a_rdata", a_rdata[1], mdat(32'h80));
        cyc_begin();
        a_req[1] = 0;
        cyc_end();

        cyc_begin();
        b_req[1] = 1; b_we[1] = 0; b_addr[1] = 32'h44;
        cyc_end();
        tick();
        cyc_begin();
        b_req[1] = 0;
        cyc_end();
        chk("drop busy", busy[1], 1'b1);
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk("drop b_ack", b_ack[1], i == 5);
        end
        tick();
        chk("drop idle", busy[1], 1'b0);

        rnd = 1;
        repeat (3000) tick();
        rnd = 0;
        cyc_begin();
        a_req = '0; b_req = '0;
        cyc_end();
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
